// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter shared types: FSM state, owner encoding
// and block geometry defaults for the I/D memory arbiter.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_WRITE = 2'd1,
    ARB_FILL  = 2'd2
  } arb_state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam int DEF_WORDS_PER_BLOCK = 8;
  localparam logic [15:0] BLK_MASK =
    ~16'(2 * DEF_WORDS_PER_BLOCK - 1);

endpackage

// File: rtl/memory_arbiter_block_counter.sv
// arb_block_counter: word counter within a block fill.
// Ports: clk, rst (async low), en, clr -> q, tc (q at max).
module arb_block_counter
  import memory_arbiter_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q,
  output logic         tc
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      q <= '0;
    else if (clr)
      q <= '0;
    else if (en)
      q <= q + W'(1);
  end

  assign tc = &q;

endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares main memory between I and D caches.
// In: I/D requests, main-memory read data. Out: memory ctrl, fill bus, stalls, dones.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IReq,
  input  logic [15:0] IAddr,
  input  logic        DReq,
  input  logic        DWrite,
  input  logic [15:0] DAddr,
  input  logic [15:0] DWriteData,
  input  logic [15:0] MainDataOut,
  input  logic        MainDataValid,
  output logic [15:0] MainAddr,
  output logic        MainEnable,
  output logic        MainWrite,
  output logic [15:0] MainDataIn,
  output logic [15:0] MemData,
  output logic [15:0] MemAddress,
  output logic        IMemCacheWriteEnable,
  output logic        DMemCacheWriteEnable,
  output logic        IMemStall,
  output logic        DMemStall,
  output logic        IDone,
  output logic        DDone
);

  localparam int CW =
    (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
  localparam logic [15:0] OFS =
    16'(2 * WORDS_PER_BLOCK - 1);

  arb_state_t  state;
  logic        owner;
  logic        issued;
  logic [15:0] base;
  logic [15:0] waddr;
  logic [15:0] wdata;

  logic [CW-1:0] ic;
  logic [CW-1:0] rc;
  logic          ic_tc;
  logic          rc_tc;

  logic is_idle;
  logic is_wr;
  logic is_fill;
  logic issuing;
  logic ret;
  logic last;

  assign is_idle = (state == ARB_IDLE);
  assign is_wr   = (state == ARB_WRITE);
  assign is_fill = (state == ARB_FILL);
  // The 3-bit counter wraps, so a flag marks all issues sent.
  assign issuing = is_fill & ~issued;
  // Returns outside FILL are stale (e.g. after a mid-fill reset).
  assign ret     = is_fill & MainDataValid;
  assign last    = ret & rc_tc;

  arb_block_counter #(.W(CW)) u_issue (
    .clk (clk),
    .rst (rst),
    .en  (issuing),
    .clr (is_idle),
    .q   (ic),
    .tc  (ic_tc)
  );

  arb_block_counter #(.W(CW)) u_ret (
    .clk (clk),
    .rst (rst),
    .en  (ret),
    .clr (is_idle),
    .q   (rc),
    .tc  (rc_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ARB_IDLE;
      owner  <= OWN_I;
      issued <= 1'b0;
      base   <= '0;
      waddr  <= '0;
      wdata  <= '0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          issued <= 1'b0;
          // D first: it is older in the pipeline.
          if (DReq) begin
            owner <= OWN_D;
            waddr <= DAddr;
            wdata <= DWriteData;
            base  <= DAddr & ~OFS;
            state <= DWrite ? ARB_WRITE : ARB_FILL;
          end else if (IReq) begin
            owner <= OWN_I;
            base  <= IAddr & ~OFS;
            state <= ARB_FILL;
          end
        end
        ARB_WRITE: state <= ARB_IDLE;
        ARB_FILL: begin
          if (issuing && ic_tc)
            issued <= 1'b1;
          if (last)
            state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  logic [15:0] ioff;
  logic [15:0] roff;

  assign ioff = {{(15-CW){1'b0}}, ic, 1'b0};
  assign roff = {{(15-CW){1'b0}}, rc, 1'b0};

  assign MainEnable = issuing | is_wr;
  assign MainWrite  = is_wr;
  assign MainAddr   = is_wr   ? waddr :
                      issuing ? base + ioff : 16'h0;
  assign MainDataIn = is_wr ? wdata : 16'h0;

  assign MemData    = MainDataOut;
  assign MemAddress = base + roff;

  assign IMemCacheWriteEnable = ret & (owner == OWN_I);
  assign DMemCacheWriteEnable = ret & (owner == OWN_D);

  assign IDone = last & (owner == OWN_I);
  assign DDone = is_wr | (last & (owner == OWN_D));

  assign IMemStall = rst &
    ((~is_idle & (owner != OWN_I)) |
     (is_idle & DReq & IReq));
  assign DMemStall = is_fill & (owner == OWN_I);

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: scoreboard bench for memory_arbiter
// with a latency-4 pipelined main-memory model.
module tb_memory_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        IReq;
  logic [15:0] IAddr;
  logic        DReq;
  logic        DWrite;
  logic [15:0] DAddr;
  logic [15:0] DWriteData;
  logic [15:0] MainDataOut;
  logic        MainDataValid;
  logic [15:0] MainAddr;
  logic        MainEnable;
  logic        MainWrite;
  logic [15:0] MainDataIn;
  logic [15:0] MemData;
  logic [15:0] MemAddress;
  logic        IMemCacheWriteEnable;
  logic        DMemCacheWriteEnable;
  logic        IMemStall;
  logic        DMemStall;
  logic        IDone;
  logic        DDone;

  memory_arbiter dut (
    .clk                  (clk),
    .rst                  (rst),
    .IReq                 (IReq),
    .IAddr                (IAddr),
    .DReq                 (DReq),
    .DWrite               (DWrite),
    .DAddr                (DAddr),
    .DWriteData           (DWriteData),
    .MainDataOut          (MainDataOut),
    .MainDataValid        (MainDataValid),
    .MainAddr             (MainAddr),
    .MainEnable           (MainEnable),
    .MainWrite            (MainWrite),
    .MainDataIn           (MainDataIn),
    .MemData              (MemData),
    .MemAddress           (MemAddress),
    .IMemCacheWriteEnable (IMemCacheWriteEnable),
    .DMemCacheWriteEnable (DMemCacheWriteEnable),
    .IMemStall            (IMemStall),
    .DMemStall            (DMemStall),
    .IDone                (IDone),
    .DDone                (DDone)
  );

  always #5 clk = ~clk;

  // Memory model: data returned = address ^ A5A5, 4 cycles later.
  logic [3:0]  vp = '0;
  logic [15:0] ap0 = '0, ap1 = '0, ap2 = '0, ap3 = '0;

  always @(posedge clk) begin
    vp  <= {vp[2:0], MainEnable & ~MainWrite};
    ap0 <= MainAddr;
    ap1 <= ap0;
    ap2 <= ap1;
    ap3 <= ap2;
  end

  assign MainDataValid = vp[3];
  assign MainDataOut   = vp[3] ? (ap3 ^ 16'hA5A5) : 16'h0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [15:0] ifill_q[$];
  logic [15:0] dfill_q[$];
  logic [15:0] iiss_q[$];
  logic [15:0] diss_q[$];
  logic [31:0] wr_q[$];

  // Scoreboard pops on every DUT memory issue and cache fill.
  always @(negedge clk) begin
    if (rst) begin
      if (MainEnable && MainWrite) begin
        if (wr_q.size() == 0)
          check("wr_unexp", 1, 0);
        else
          check("wr", {MainAddr, MainDataIn}, wr_q.pop_front());
      end
      if (MainEnable && !MainWrite) begin
        if (DMemStall) begin
          if (iiss_q.size() == 0) check("iiss_unexp", 1, 0);
          else check("iiss", MainAddr, iiss_q.pop_front());
        end else begin
          if (diss_q.size() == 0) check("diss_unexp", 1, 0);
          else check("diss", MainAddr, diss_q.pop_front());
        end
      end
      if (IMemCacheWriteEnable) begin
        if (ifill_q.size() == 0) check("ifill_unexp", 1, 0);
        else begin
          logic [15:0] e;
          e = ifill_q.pop_front();
          check("ifill_addr", MemAddress, e);
          check("ifill_data", MemData, e ^ 16'hA5A5);
        end
      end
      if (DMemCacheWriteEnable) begin
        if (dfill_q.size() == 0) check("dfill_unexp", 1, 0);
        else begin
          logic [15:0] e;
          e = dfill_q.pop_front();
          check("dfill_addr", MemAddress, e);
          check("dfill_data", MemData, e ^ 16'hA5A5);
        end
      end
    end
  end

  int idone_at, ddone_at, i_iss_first;
  int i_we_first, i_we_last;
  int istall_cnt, dstall_cnt, me_cnt;

  function automatic logic [63:0] outs();
    return {8'h0, MainAddr, MainEnable, MainWrite, MainDataIn,
            MemAddress, IMemCacheWriteEnable,
            DMemCacheWriteEnable, IMemStall, DMemStall,
            IDone, DDone};
  endfunction

  // Called at posedge+1; cycle 0 is the current cycle.
  task automatic run(input int ncyc,
                     input int i_at, input logic [15:0] ia,
                     input int d_at, input logic dw,
                     input logic [15:0] da, input logic [15:0] dd);
    idone_at = -1; ddone_at = -1; i_iss_first = -1;
    i_we_first = -1; i_we_last = -1;
    istall_cnt = 0; dstall_cnt = 0; me_cnt = 0;
    for (int k = 0; k < ncyc; k++) begin
      if (k == i_at) begin
        IReq = 1'b1;
        IAddr = ia;
        for (int j = 0; j < 8; j++) begin
          iiss_q.push_back((ia & 16'hFFF0) + 16'(2 * j));
          ifill_q.push_back((ia & 16'hFFF0) + 16'(2 * j));
        end
      end
      if (k == d_at) begin
        DReq = 1'b1;
        DWrite = dw;
        DAddr = da;
        DWriteData = dd;
        if (dw)
          wr_q.push_back({da, dd});
        else
          for (int j = 0; j < 8; j++) begin
            diss_q.push_back((da & 16'hFFF0) + 16'(2 * j));
            dfill_q.push_back((da & 16'hFFF0) + 16'(2 * j));
          end
      end
      if (idone_at >= 0 && k == idone_at + 1) IReq = 1'b0;
      if (ddone_at >= 0 && k == ddone_at + 1) begin
        DReq = 1'b0;
        DWrite = 1'b0;
      end
      @(negedge clk);
      if (IDone && idone_at < 0) idone_at = k;
      if (DDone && ddone_at < 0) ddone_at = k;
      if (MainEnable && !MainWrite && DMemStall && i_iss_first < 0)
        i_iss_first = k;
      if (IMemCacheWriteEnable) begin
        if (i_we_first < 0) i_we_first = k;
        i_we_last = k;
      end
      istall_cnt += int'(IMemStall);
      dstall_cnt += int'(DMemStall);
      me_cnt += int'(MainEnable);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic q_empty(input string tag);
    check(tag, ifill_q.size() + dfill_q.size() + iiss_q.size()
               + diss_q.size() + wr_q.size(), 0);
  endtask

  initial begin
    rst = 1'b0;
    IReq = 1'b0; IAddr = '0;
    DReq = 1'b0; DWrite = 1'b0;
    DAddr = '0; DWriteData = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs", outs(), 64'h0);
    check("reset_memdata", MemData, 16'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("post_reset_outs", outs(), 64'h0);
    @(posedge clk);
    #1;

    // I fill alone
    run(16, 0, 16'h1234, -1, 1'b0, 16'h0, 16'h0);
    check("t1_idone", idone_at, 12);
    check("t1_iss_first", i_iss_first, 1);
    check("t1_we_first", i_we_first, 5);
    check("t1_we_last", i_we_last, 12);
    check("t1_dstall", dstall_cnt, 12);
    check("t1_istall", istall_cnt, 0);
    check("t1_me", me_cnt, 8);
    q_empty("t1_q");
    idle(2);

    // Simultaneous I and D fill: D wins
    run(28, 0, 16'h4444, 0, 1'b0, 16'h8008, 16'h0);
    check("t2_ddone", ddone_at, 12);
    check("t2_idone", idone_at, 25);
    check("t2_iss_first", i_iss_first, 14);
    check("t2_istall", istall_cnt, 13);
    check("t2_dstall", dstall_cnt, 12);
    check("t2_me", me_cnt, 16);
    q_empty("t2_q");
    idle(2);

    // Write-through
    run(4, -1, 16'h0, 0, 1'b1, 16'h0042, 16'hBEEF);
    check("t3_ddone", ddone_at, 1);
    check("t3_me", me_cnt, 1);
    check("t3_istall", istall_cnt, 1);
    check("t3_idone", idone_at, -1);
    q_empty("t3_q");
    idle(2);

    // I request arriving mid D fill
    run(28, 3, 16'h3002, 0, 1'b0, 16'h2010, 16'h0);
    check("t4_ddone", ddone_at, 12);
    check("t4_iss_first", i_iss_first, 14);
    check("t4_idone", idone_at, 25);
    check("t4_istall", istall_cnt, 12);
    q_empty("t4_q");
    idle(2);

    // Reset mid I fill at cycle 6
    run(6, 0, 16'h5550, -1, 1'b0, 16'h0, 16'h0);
    rst = 1'b0;
    IReq = 1'b0;
    @(negedge clk);
    check("t5_reset_outs", outs(), 64'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    ifill_q.delete();
    iiss_q.delete();
    run(10, -1, 16'h0, -1, 1'b0, 16'h0, 16'h0);
    check("t5_stale_we", i_we_first, -1);
    check("t5_me", me_cnt, 0);
    check("t5_idone", idone_at, -1);
    q_empty("t5_q");

    // Wrap/alignment at the top of memory
    run(15, 0, 16'hFFFE, -1, 1'b0, 16'h0, 16'h0);
    check("t6_idone", idone_at, 12);
    check("t6_iss_first", i_iss_first, 1);
    check("t6_we_last", i_we_last, 12);
    q_empty("t6_q");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Shares the single-ported, pipelined main memory between the instruction cache (I) and the data cache (D).
- Sequences 8-word block fills on cache misses and single-word write-throughs from the D-cache.
- Drives each cache's MemData/MemAddress/MemCacheWriteEnable/MemStall inputs and the main-memory control.
- Sits between both CacheInterface instances (IF and MEM stages) and the main memory.

Parameters:
- WORDS_PER_BLOCK, 8, 16-bit words per cache block (power of 2); block bytes = 2*WORDS_PER_BLOCK.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- IReq  in  1  I-cache miss request; held until IDone.
- IAddr  in  16  I-cache miss byte address.
- DReq  in  1  D-cache request (read miss or write); held until DDone.
- DWrite  in  1  qualifies DReq: 1 = single-word write-through, 0 = block fill.
- DAddr  in  16  D-cache byte address.
- DWriteData  in  16  write data.
- MainDataOut  in  16  read data returned by main memory.
- MainDataValid  in  1  MainDataOut valid; read latency is fixed ≥1 and unknown to this block.
- MainAddr  out  16  memory address.
- MainEnable  out  1  memory access this cycle.
- MainWrite  out  1  write qualifier.
- MainDataIn  out  16  write data to memory.
- MemData  out  16  fill word, broadcast to both caches.
- MemAddress  out  16  byte address of MemData.
- IMemCacheWriteEnable  out  1  write MemData into the I-cache.
- DMemCacheWriteEnable  out  1  write MemData into the D-cache.
- IMemStall  out  1  memory busy serving D.
- DMemStall  out  1  memory busy serving I.
- IDone  out  1  1-cycle pulse, I fill complete.
- DDone  out  1  1-cycle pulse, D fill or write complete.

Behaviour:
- Reset (rst=0, async): state IDLE, counters 0, owner none. All outputs 0 except the passthrough MemData (= MainDataOut).
- States:
  - IDLE: samples requests. Priority: DReq > IReq; the data access is older in the pipeline.
    - DReq & DWrite -> WRITE.
    - DReq & !DWrite -> FILL, owner=D.
    - else IReq -> FILL, owner=I.
    - Latch base = Addr with low log2(2*WORDS_PER_BLOCK) bits cleared; latch write address/data.
  - WRITE (1 cycle): MainEnable=1, MainWrite=1, MainAddr=latched DAddr, MainDataIn=latched DWriteData; DDone=1; -> IDLE.
  - FILL:
    - Issue: issue counter ic counts 0..WORDS_PER_BLOCK-1. While ic < WORDS_PER_BLOCK: MainEnable=1, MainWrite=0, MainAddr=base+2*ic, ic++ each cycle. No gaps.
    - Return: each cycle with MainDataValid=1, return counter rc increments. Owner's MemCacheWriteEnable=1, MemAddress=base+2*rc.
    - Exit: on the return with rc=WORDS_PER_BLOCK-1, owner's Done=1 and -> IDLE.
    - Returns overlap issues when latency < WORDS_PER_BLOCK; both counters run independently.
- Stall outputs (combinational):
  - IMemStall = (state≠IDLE & owner≠I) | (state=IDLE & DReq & IReq).
  - DMemStall = state=FILL & owner=I.
- MemCacheWriteEnable and Done of the non-owner are always 0.
- MainDataValid in IDLE or WRITE is ignored; this covers in-flight returns after a mid-fill reset.
- A request held across the Done cycle is re-sampled in the following IDLE cycle. This gives a 1-cycle IDLE gap per transaction; the caches drop Req on Done.
- Address arithmetic is 16-bit and wraps at 0xFFFF; never crosses a block because base is aligned.
- Timing at latency 4, request seen at cycle 0:
  - Issues in cycles 1–8, returns in cycles 5–12.
  - IDone/DDone in cycle 12, IDLE in cycle 13.
- Reset mid-transaction aborts immediately; no Done pulse. The caches are reset by the same rst.

Decomposition:
- Shared package holds:
  - State encoding constants ARB_IDLE=2'd0, ARB_WRITE=2'd1, ARB_FILL=2'd2.
  - Owner encoding OWN_I=1'b0, OWN_D=1'b1.
  - Default WORDS_PER_BLOCK and the block-offset mask.
- One natural sub-module, arb_block_counter: the 3-bit issue/return counter with enable, clear and terminal-count flag, instantiated twice.

Test Plan (memory model latency 4):
- I fill alone: IReq=1, IAddr=0x1234 at cycle 0.
  - MainAddr 0x1230,0x1232,…,0x123E in cycles 1–8.
  - IMemCacheWriteEnable in cycles 5–12 with MemAddress 0x1230..0x123E.
  - IDone pulse at 12; DMemStall=1 in cycles 1–12.
- Simultaneous requests: IReq and DReq (DWrite=0, DAddr=0x8008) at cycle 0.
  - D block 0x8000 filled first, IMemStall=1 throughout, DDone at 12.
  - I fill issues from cycle 14; IDone at 25.
- Write-through: DReq=1, DWrite=1, DAddr=0x0042, DWriteData=0xBEEF.
  - Cycle 1: MainEnable=1, MainWrite=1, MainAddr=0x0042, MainDataIn=0xBEEF, DDone=1.
  - Cycle 2: IDLE.
- I request arriving mid-D-fill (cycle 3): no grant and IMemStall=1 until D completes, then I is granted in the next IDLE cycle.
- Reset mid-fill: rst=0 at cycle 6 of an I fill.
  - All outputs 0 that cycle; state IDLE after release.
  - Stale MainDataValid pulses produce no CacheWriteEnable.
- Wrap/alignment: IAddr=0xFFFE -> fill addresses 0xFFF0..0xFFFE, no carry out.
